// File: rtl/rr_tag_tree_pkg.sv
// Shared definitions for the round-robin tag tree: width helper, delay
// configuration encodings and the rule deciding which node depths are registered.
package rr_tag_tree_pkg;

    typedef enum int unsigned {
        DELAY_COMB = 0,
        DELAY_ODD  = 1,
        DELAY_ALL  = 2
    } delay_conf_e;

    // Ceiling log2, never below 1 so a single-leaf tree still has a 1-bit tag.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    function automatic bit node_registered(input int unsigned conf, input int unsigned depth);
        case (conf)
            DELAY_ODD: return depth[0];
            DELAY_ALL: return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_tag_tree_node.sv
// Two-input arbitration node: child selection, round-robin pointer,
// optional output register and ack steering back to the chosen child.
module rr_tree_node
    import rr_tag_tree_pkg::*;
#(
    parameter int unsigned TAG_SZ       = 2,
    parameter bit          ENABLE_DELAY = 1'b0,
    parameter bit          FAIR         = 1'b1
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_l_rdy,
    input  logic [TAG_SZ-1:0] i_l_tag,
    output logic              o_l_ack,
    input  logic              i_r_rdy,
    input  logic [TAG_SZ-1:0] i_r_tag,
    output logic              o_r_ack,
    output logic              o_rdy,
    output logic [TAG_SZ-1:0] o_tag,
    input  logic              i_ack
);

    logic              w_sel_l;
    logic              w_take;
    logic [TAG_SZ-1:0] w_sel_tag;
    logic              r_ptr;   // 0 prefers the left child on a tie

    assign w_sel_l   = i_l_rdy & (~i_r_rdy | ~FAIR | ~r_ptr);
    assign w_sel_tag = w_sel_l ? i_l_tag : i_r_tag;
    assign o_l_ack   = w_take & w_sel_l;
    assign o_r_ack   = w_take & i_r_rdy & ~w_sel_l;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 1'b0;
        end else if (FAIR && w_take && i_l_rdy && i_r_rdy) begin
            r_ptr <= ~r_ptr;
        end
    end

    generate
        if (ENABLE_DELAY) begin : g_reg
            logic              r_valid;
            logic [TAG_SZ-1:0] r_tag;

            // An empty or draining register accepts a new child every cycle.
            assign w_take = ~r_valid | i_ack;
            assign o_rdy  = r_valid;
            assign o_tag  = r_tag;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_valid <= 1'b0;
                    r_tag   <= '0;
                end else if (w_take) begin
                    r_valid <= i_l_rdy | i_r_rdy;
                    r_tag   <= w_sel_tag;
                end
            end
        end else begin : g_comb
            assign w_take = i_ack & (i_l_rdy | i_r_rdy);
            assign o_rdy  = i_l_rdy | i_r_rdy;
            assign o_tag  = w_sel_tag;
        end
    endgenerate

endmodule

// File: rtl/rr_tag_tree.sv
// Heap of two-input round-robin nodes arbitrating N leaf requesters down to
// one tag/ready/ack handshake at the root.
module rr_tag_tree
    import rr_tag_tree_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned TAG_SZ      = clog2(N),
    parameter int unsigned DELAY_CONF  = 1,
    parameter int unsigned FAIR        = 1,
    parameter int unsigned CUSTOM_TAGS = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    output logic [TAG_SZ-1:0]     tag,
    output logic                  rdy,
    input  logic                  ack,
    input  logic [N-1:0]          rdy_in,
    output logic [N-1:0]          ack_out,
    input  logic [N*TAG_SZ-1:0]   custom_tags
);

    logic [TAG_SZ-1:0] w_leaf_tag [N];

    generate
        if (CUSTOM_TAGS != 0) begin : g_ctag
            for (genvar j = 0; j < N; j++) begin : g_leaf
                assign w_leaf_tag[j] = custom_tags[TAG_SZ*(j+1)-1 -: TAG_SZ];
            end
        end else begin : g_itag
            logic w_unused_tags;
            assign w_unused_tags = ^custom_tags;
            for (genvar j = 0; j < N; j++) begin : g_leaf
                assign w_leaf_tag[j] = TAG_SZ'(j);
            end
        end

        if (N == 1) begin : g_single
            logic w_unused_clk;
            assign w_unused_clk = clk;
            assign tag          = w_leaf_tag[0];
            assign rdy          = rdy_in[0];
            assign ack_out[0]   = ack & rdy_in[0] & rst;
        end else begin : g_tree
            // Each slot lives in its own generate scope so the tree is not one
            // self-referencing array; children and parents are reached by index.
            for (genvar k = 0; k < N - 1; k++) begin : g_node
                localparam int unsigned DEPTH = clog2(N - k);
                logic              w_l_rdy, w_r_rdy, w_o_rdy;
                logic              w_ack_in, w_l_ack, w_r_ack;
                logic [TAG_SZ-1:0] w_l_tag, w_r_tag, w_o_tag;

                if (2*k < N) begin : g_l_leaf
                    assign w_l_rdy = rdy_in[2*k];
                    assign w_l_tag = w_leaf_tag[2*k];
                end else begin : g_l_node
                    assign w_l_rdy = g_node[2*k-N].w_o_rdy;
                    assign w_l_tag = g_node[2*k-N].w_o_tag;
                end

                if (2*k + 1 < N) begin : g_r_leaf
                    assign w_r_rdy = rdy_in[2*k+1];
                    assign w_r_tag = w_leaf_tag[2*k+1];
                end else begin : g_r_node
                    assign w_r_rdy = g_node[2*k+1-N].w_o_rdy;
                    assign w_r_tag = g_node[2*k+1-N].w_o_tag;
                end

                if (k == N - 2) begin : g_root_ack
                    assign w_ack_in = ack;
                end else if ((N + k) % 2 == 0) begin : g_ack_l
                    assign w_ack_in = g_node[(N+k)/2].w_l_ack;
                end else begin : g_ack_r
                    assign w_ack_in = g_node[(N+k)/2].w_r_ack;
                end

                rr_tree_node #(
                    .TAG_SZ       (TAG_SZ),
                    .ENABLE_DELAY (node_registered(DELAY_CONF, DEPTH)),
                    .FAIR         (FAIR != 0)
                ) u_node (
                    .i_clk   (clk),
                    .i_rst_n (rst),
                    .i_l_rdy (w_l_rdy),
                    .i_l_tag (w_l_tag),
                    .o_l_ack (w_l_ack),
                    .i_r_rdy (w_r_rdy),
                    .i_r_tag (w_r_tag),
                    .o_r_ack (w_r_ack),
                    .o_rdy   (w_o_rdy),
                    .o_tag   (w_o_tag),
                    .i_ack   (w_ack_in)
                );
            end

            assign tag = g_node[N-2].w_o_tag;
            assign rdy = g_node[N-2].w_o_rdy;

            for (genvar j = 0; j < N; j++) begin : g_grant
                if (j % 2 == 0) begin : g_even
                    assign ack_out[j] = rst & g_node[j/2].w_l_ack;
                end else begin : g_odd
                    assign ack_out[j] = rst & g_node[j/2].w_r_ack;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rr_tag_tree.sv
// Directed and randomised checks of rr_tag_tree across several parameter sets.
module tb_rr_tag_tree;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_r1;
    int   n_vec  = 0;
    int   n_fail = 0;

    // a: comb/fair, b: comb/fixed, r2: all registered, c: custom tags,
    // r1: odd registered, s: N=1, t: N=3 odd registered
    logic [1:0] a_tag, b_tag, r2_tag, r1_tag, t_tag;
    logic [2:0] c_tag;
    logic [0:0] s_tag;
    logic       a_rdy, a_ack, b_rdy, b_ack, r2_rdy, r2_ack, c_rdy, c_ack;
    logic       r1_rdy, r1_ack, s_rdy, s_ack, t_rdy, t_ack;
    logic [3:0] a_rin, a_aout, b_rin, b_aout, r2_rin, r2_aout, c_rin, c_aout, r1_rin, r1_aout;
    logic [0:0] s_rin, s_aout;
    logic [2:0] t_rin, t_aout, t_nxt;
    logic [0:0] s_nxt;

    int q[$];
    int t_q[$];
    int t_wait[3];
    int lat;

    rr_tag_tree #(.N(4), .DELAY_CONF(0), .FAIR(1)) u_a (
        .clk(clk), .rst(rst), .tag(a_tag), .rdy(a_rdy), .ack(a_ack),
        .rdy_in(a_rin), .ack_out(a_aout), .custom_tags(8'h00));
    rr_tag_tree #(.N(4), .DELAY_CONF(0), .FAIR(0)) u_b (
        .clk(clk), .rst(rst), .tag(b_tag), .rdy(b_rdy), .ack(b_ack),
        .rdy_in(b_rin), .ack_out(b_aout), .custom_tags(8'h00));
    rr_tag_tree #(.N(4), .DELAY_CONF(2), .FAIR(1)) u_r2 (
        .clk(clk), .rst(rst), .tag(r2_tag), .rdy(r2_rdy), .ack(r2_ack),
        .rdy_in(r2_rin), .ack_out(r2_aout), .custom_tags(8'h00));
    rr_tag_tree #(.N(4), .TAG_SZ(3), .DELAY_CONF(0), .CUSTOM_TAGS(1)) u_c (
        .clk(clk), .rst(rst), .tag(c_tag), .rdy(c_rdy), .ack(c_ack),
        .rdy_in(c_rin), .ack_out(c_aout), .custom_tags({3'd7, 3'd5, 3'd3, 3'd1}));
    rr_tag_tree #(.N(4), .DELAY_CONF(1), .FAIR(1)) u_r1 (
        .clk(clk), .rst(rst_r1), .tag(r1_tag), .rdy(r1_rdy), .ack(r1_ack),
        .rdy_in(r1_rin), .ack_out(r1_aout), .custom_tags(8'h00));
    rr_tag_tree #(.N(1), .DELAY_CONF(1), .FAIR(1)) u_s (
        .clk(clk), .rst(rst), .tag(s_tag), .rdy(s_rdy), .ack(s_ack),
        .rdy_in(s_rin), .ack_out(s_aout), .custom_tags(1'b0));
    rr_tag_tree #(.N(3), .DELAY_CONF(1), .FAIR(1)) u_t (
        .clk(clk), .rst(rst), .tag(t_tag), .rdy(t_rdy), .ack(t_ack),
        .rdy_in(t_rin), .ack_out(t_aout), .custom_tags(6'h00));

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; rst_r1 = 1'b0;
        a_rin = 4'b0010; a_ack = 1'b1;
        b_rin = '0; b_ack = 1'b0;
        r2_rin = 4'hF; r2_ack = 1'b1;
        c_rin = '0; c_ack = 1'b0;
        r1_rin = 4'hF; r1_ack = 1'b1;
        s_rin = '0; s_ack = 1'b0;
        t_rin = '0; t_ack = 1'b0;

        // reset state
        @(negedge clk); @(negedge clk);
        check("rst_r2_rdy", r2_rdy, 0);
        check("rst_r2_tag", r2_tag, 0);
        check("rst_r2_ack_out", r2_aout, 0);
        check("rst_r1_rdy", r1_rdy, 0);
        check("rst_r1_ack_out", r1_aout, 0);
        check("rst_a_comb_rdy", a_rdy, 1);
        check("rst_a_comb_tag", a_tag, 1);
        check("rst_a_ack_out", a_aout, 0);

        step();
        rst = 1'b1; rst_r1 = 1'b1;
        a_rin = '0; a_ack = 1'b0; r2_rin = '0; r1_rin = '0; r1_ack = 1'b0;
        repeat (3) step();

        // fair combinational tree, continuous ack
        a_rin = 4'hF; a_ack = 1'b1;
        q = '{0, 2, 1, 3, 0, 2, 1, 3};
        while (q.size() > 0) begin
            int e;
            @(negedge clk);
            e = q.pop_front();
            check("a_rdy", a_rdy, 1);
            check("a_tag", a_tag, e);
            check("a_grant", a_aout, 32'd1 << e);
            step();
        end
        a_ack = 1'b0;
        @(negedge clk);
        check("a_stall_tag", a_tag, 0);
        check("a_stall_grant", a_aout, 0);
        step();
        @(negedge clk);
        check("a_stall_hold_tag", a_tag, 0);
        step();
        a_ack = 1'b1;
        q = '{0, 2};
        while (q.size() > 0) begin
            int e;
            @(negedge clk);
            e = q.pop_front();
            check("a_resume_tag", a_tag, e);
            step();
        end
        a_rin = '0; a_ack = 1'b0;

        // fixed priority
        b_rin = 4'hF; b_ack = 1'b1;
        q = '{0, 0, 0, 0};
        while (q.size() > 0) begin
            int e;
            @(negedge clk);
            e = q.pop_front();
            check("b_tag", b_tag, e);
            check("b_grant", b_aout, 32'd1 << e);
            step();
        end
        b_rin = 4'b1110; q.push_back(1);
        @(negedge clk);
        check("b_tag_1110", b_tag, q.pop_front());
        check("b_grant_1110", b_aout, 4'b0010);
        step();
        b_rin = 4'b1100; q.push_back(2);
        @(negedge clk);
        check("b_tag_1100", b_tag, q.pop_front());
        step();
        b_rin = 4'b1000; q.push_back(3);
        @(negedge clk);
        check("b_tag_1000", b_tag, q.pop_front());
        step();
        b_rin = '0; b_ack = 1'b0;

        // fully registered tree: latency of one leaf
        r2_ack = 1'b1; r2_rin = 4'b1000; q.push_back(3);
        @(negedge clk);
        check("r2_grant_c0", r2_aout, 4'b1000);
        check("r2_rdy_c0", r2_rdy, 0);
        step();
        r2_rin = '0;
        lat = -1;
        for (int c = 1; c <= 6 && lat < 0; c++) begin
            @(negedge clk);
            if (r2_rdy) lat = c;
            else step();
        end
        check("r2_latency", lat, 2);
        check("r2_tag", r2_tag, q.pop_front());
        step();
        @(negedge clk);
        check("r2_rdy_drop", r2_rdy, 0);
        step();

        // fully registered tree: no bubbles under continuous ack
        r2_rin = 4'hF;
        q = '{0, 2, 1, 3, 0, 2, 1, 3};
        lat = -1;
        for (int c = 0; c <= 6 && lat < 0; c++) begin
            @(negedge clk);
            if (r2_rdy) lat = c;
            else step();
        end
        check("r2_fill_latency", lat, 2);
        while (q.size() > 0) begin
            check("r2_stream_rdy", r2_rdy, 1);
            check("r2_stream_tag", r2_tag, q.pop_front());
            check("r2_stream_onegrant", $countones(r2_aout), 1);
            step();
            @(negedge clk);
        end
        step();
        r2_rin = '0;
        repeat (4) step();

        // custom tags
        c_rin = 4'b0100; c_ack = 1'b0; q.push_back(5);
        @(negedge clk);
        check("c_rdy", c_rdy, 1);
        check("c_tag", c_tag, q.pop_front());
        check("c_no_grant", c_aout, 0);
        step();
        c_ack = 1'b1;
        @(negedge clk);
        check("c_grant", c_aout, 4'b0100);
        step();
        c_rin = 4'b0001; q.push_back(1);
        @(negedge clk);
        check("c_tag_leaf0", c_tag, q.pop_front());
        step();
        c_rin = 4'b1000; q.push_back(7);
        @(negedge clk);
        check("c_tag_leaf3", c_tag, q.pop_front());
        step();
        c_rin = '0; c_ack = 1'b0;

        // stalled odd-registered tree, then reset mid-transfer
        r1_rin = 4'hF; r1_ack = 1'b0;
        @(negedge clk);
        check("r1_grant_c0", r1_aout, 4'b0001);
        check("r1_rdy_c0", r1_rdy, 0);
        step();
        @(negedge clk);
        check("r1_rdy_c1", r1_rdy, 1);
        check("r1_tag_c1", r1_tag, 0);
        check("r1_stall_grant_c1", r1_aout, 0);
        step();
        @(negedge clk);
        check("r1_rdy_c2", r1_rdy, 1);
        check("r1_stall_grant_c2", r1_aout, 0);
        step();
        rst_r1 = 1'b0;
        #1;
        check("r1_async_rdy", r1_rdy, 0);
        check("r1_async_tag", r1_tag, 0);
        check("r1_async_grant", r1_aout, 0);
        @(negedge clk);
        check("r1_rst_grant", r1_aout, 0);
        step();
        rst_r1 = 1'b1;
        @(negedge clk);
        check("r1_rel_grant", r1_aout, 4'b0001);
        check("r1_rel_rdy", r1_rdy, 0);
        step();
        r1_ack = 1'b1;
        q = '{0, 2, 1, 3};
        while (q.size() > 0) begin
            @(negedge clk);
            check("r1_rel_rdy_stream", r1_rdy, 1);
            check("r1_rel_tag", r1_tag, q.pop_front());
            step();
        end
        r1_rin = '0; r1_ack = 1'b0;

        // random traffic on N=1 and N=3
        for (int k = 0; k < 3; k++) t_wait[k] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            check("s_rdy", s_rdy, s_rin);
            check("s_tag", s_tag, 0);
            check("s_grant", s_aout, s_ack & s_rin);

            check("t_grant_not_ready", t_aout & ~t_rin, 0);
            check("t_multi_grant", $countones(t_aout) > 1, 0);
            if (t_rdy && t_ack) begin
                if (t_q.size() == 0) check("t_unexpected_tag", t_tag, 3);
                else check("t_tag", t_tag, t_q.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                if (t_aout[k]) t_q.push_back(k);
                if (!t_rin[k] || t_aout[k]) t_wait[k] = 0;
                else if (t_rdy && t_ack) t_wait[k]++;
                check("t_starvation", t_wait[k] > 6, 0);
            end

            s_nxt = s_rin & ~s_aout;
            if (s_nxt[0]) begin
                if ($urandom_range(15, 0) == 0) s_nxt[0] = 1'b0;
            end else if (!s_aout[0] && $urandom_range(2, 0) == 0) begin
                s_nxt[0] = 1'b1;
            end
            t_nxt = t_rin & ~t_aout;
            for (int k = 0; k < 3; k++) begin
                if (t_nxt[k]) begin
                    if ($urandom_range(15, 0) == 0) t_nxt[k] = 1'b0;
                end else if (!t_aout[k] && $urandom_range(2, 0) == 0) begin
                    t_nxt[k] = 1'b1;
                end
            end
            step();
            s_rin = s_nxt;
            t_rin = t_nxt;
            s_ack = ($urandom_range(3, 0) != 0);
            t_ack = ($urandom_range(3, 0) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_tag_tree.md
RR_TAG_TREE -- requirements
Module: rr_tag_tree

Interface
REQ-001 Parameter N, default 4: number of leaf requesters, 1..65536.
REQ-002 Parameter TAG_SZ, default clog2(N), with clog2(1)=1: tag width.
REQ-003 Parameter DELAY_CONF, default 1: 0 = all combinational; 1 = register on odd depths (root is depth 1); 2 = register on every node.
REQ-004 Parameter FAIR, default 1: 0 = fixed left priority; 1 = per-node round-robin.
REQ-005 Parameter CUSTOM_TAGS, default 0: 0 = leaf k tag is k; 1 = tag taken from custom_tags.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 tag  output  TAG_SZ  tag of the winning leaf.
REQ-009 rdy  output  1  tag valid.
REQ-010 ack  input  1  consumer accepts tag; meaningful only when rdy=1.
REQ-011 rdy_in  input  N  per-leaf request.
REQ-012 ack_out  output  N  per-leaf grant, at most one bit high per cycle.
REQ-013 custom_tags  input  N*TAG_SZ  leaf k tag = bits [TAG_SZ*(k+1)-1 -: TAG_SZ]; ignored when CUSTOM_TAGS=0.

Function
REQ-014 Topology: heap of N-1 two-input nodes; slots 0..N-1 are leaves; node k joins slots 2k and 2k+1 into slot N+k; slot 2N-2 is the root.
REQ-015 Node depth = clog2(N-k); the node is registered per DELAY_CONF.
REQ-016 Selection: one child ready -> that child; both ready -> left if FAIR=0, else the side given by the node pointer.
REQ-017 Pointer resets to left, flips to the opposite side only on a node handshake with both children ready, and otherwise holds.
REQ-018 Combinational node: rdy = left_rdy | right_rdy; tag = selected child's tag; ack is routed only to the selected child.
REQ-019 Registered node output: holds valid, tag and side; rdy = valid.
REQ-020 Registered node load: load_en = !valid | ack.
REQ-021 Registered node capture: on load_en the node captures the selected child's tag, sets valid = any child ready, and acks the selected child in the same cycle.
REQ-022 Registered node throughput: one handshake per cycle under continuous ack; no bubbles.
REQ-023 Latency from rdy_in rising to root rdy = number of registered nodes on that leaf's path, in cycles; 0 for DELAY_CONF=0.
REQ-024 Grant: ack_out[k] is high only in the cycle leaf k's request is consumed by its parent node; a leaf drops or keeps rdy_in[k] after that cycle at its discretion.
REQ-025 Leaf withdrawal: a leaf deasserting rdy_in without ack_out is legal; no grant is issued to it.
REQ-026 N=1: no nodes; tag = leaf 0 tag, rdy = rdy_in[0], ack_out[0] = ack; no state.
REQ-027 Non-power-of-two N: the same heap; fairness is per node only, not globally uniform.
REQ-028 ack while rdy=0 has no effect.

Reset
REQ-029 rst low asynchronously clears all valid registers and resets all pointers to left; no ack_out is issued while rst=0.
REQ-030 Outputs in reset: rdy=0 and tag=0 when the root is registered; combinational paths still reflect their inputs.
REQ-031 Reset mid-transfer discards all registered tags; affected leaves have not been acked and re-arbitrate after release.

Structure
REQ-032 Shared package: clog2 function, DELAY_CONF encodings, and the depth-to-register-enable rule.
REQ-033 Sub-module rr_tree_node holds selection, pointer, optional output register and ack steering, parameterised by TAG_SZ, ENABLE_DELAY and FAIR.

Verification
REQ-034 N=4, DELAY_CONF=0, FAIR=1, rdy_in=4'b1111, ack held 1 -> tag sequence 0,2,1,3,0,... with one grant per cycle.
REQ-035 Same setup with FAIR=0 -> tag 0 every cycle and ack_out=4'b0001 every cycle.
REQ-036 N=4, DELAY_CONF=2, rdy_in=4'b1000 from cycle 0, ack=1 -> ack_out[3] in cycle 0; root rdy=1 with tag=3 in cycle 2; then rdy drops when rdy_in is cleared after the ack.
REQ-037 N=4, CUSTOM_TAGS=1, TAG_SZ=3, custom_tags={3'd7,3'd5,3'd3,3'd1}, rdy_in=4'b0100 -> tag=5, and ack yields ack_out=4'b0100.
REQ-038 N=4, DELAY_CONF=1, all leaves ready, ack stalled 0 for 3 cycles then rst low one cycle -> rdy=0, ack_out=0, pointers left; after release the first tag is 0.
REQ-039 N=1 and N=3 with random rdy_in/ack -> every granted leaf was ready, no leaf is granted twice per request, and with FAIR=1 no ready leaf starves beyond 2*N consecutive handshakes.
